// File: rtl/ntt_result_reader.sv
// ntt_result_reader: captures one NTT result phase (all cores, both halves,
// one row per beat) into a local buffer, then drains the 2048 words in
// processor load-format index order over a valid/ready stream.
module ntt_result_reader #(
    parameter int LOG_CORE_COUNT = 5
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    output_active,
    input  logic [2**LOG_CORE_COUNT-1:0][1:0][59:0] out,
    input  logic [8:0]                              address_out,
    output logic                                    m_valid,
    input  logic                                    m_ready,
    output logic [59:0]                             m_data,
    output logic [10:0]                             m_index,
    output logic                                    m_last,
    output logic                                    busy,
    output logic                                    short_frame,
    output logic                                    overrun,
    input  logic                                    clear_flags
);

    localparam int CORES = 1 << LOG_CORE_COUNT;
    localparam int ROW_W = 10 - LOG_CORE_COUNT;
    localparam int ROWS  = 1 << ROW_W;
    localparam int CNT_W = ROW_W + 1;

    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

    state_t state_q, state_d;

    // One buffer row holds a full beat: [half][core] words.
    logic [1:0][CORES-1:0][59:0] mem [ROWS];

    logic [CNT_W-1:0] beat_cnt;
    logic [10:0]      rd_idx;
    logic             rd_done;
    logic             load;
    logic             capture_beat;
    logic [ROW_W-1:0] wr_row;
    logic [59:0]      rd_word;
    logic             unused_addr;

    // Upper row-address bits are not meaningful for this core count.
    assign unused_addr  = ^address_out[8:ROW_W];
    assign wr_row       = address_out[ROW_W-1:0];
    assign capture_beat = output_active && (state_q != DRAIN) && !reset;
    assign rd_word      = mem[rd_idx[ROW_W-1:0]][rd_idx[10]][rd_idx[9:ROW_W]];
    assign busy         = (state_q != IDLE);

    // Output register reloads whenever it is empty or being accepted.
    assign load = (state_q == DRAIN) && !rd_done && (!m_valid || m_ready);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (output_active) state_d = CAPTURE;
            CAPTURE: if (!output_active) state_d = DRAIN;
            DRAIN:   if (m_valid && m_ready && m_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Buffer write: every captured beat stores all cores and halves at its row.
    always_ff @(posedge clk) begin
        if (capture_beat) begin
            for (int c = 0; c < CORES; c++) begin
                for (int h = 0; h < 2; h++) begin
                    mem[wr_row][h][c] <= out[c][h];
                end
            end
        end
    end

    // Beat counter and sticky status flags; a set condition beats clear_flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt    <= '0;
            short_frame <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (state_q == IDLE && output_active)
                beat_cnt <= CNT_W'(1);
            else if (state_q == CAPTURE && output_active && beat_cnt < CNT_W'(ROWS))
                beat_cnt <= beat_cnt + 1'b1;

            if (state_q == CAPTURE && !output_active && beat_cnt < CNT_W'(ROWS))
                short_frame <= 1'b1;
            else if (clear_flags)
                short_frame <= 1'b0;

            if (state_q == DRAIN && output_active)
                overrun <= 1'b1;
            else if (clear_flags)
                overrun <= 1'b0;
        end
    end

    // Drain read pointer and the single output register stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_idx  <= '0;
            rd_done <= 1'b0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            m_data  <= '0;
            m_index <= '0;
        end else if (state_q != DRAIN) begin
            rd_idx  <= '0;
            rd_done <= 1'b0;
        end else if (load) begin
            m_valid <= 1'b1;
            m_data  <= rd_word;
            m_index <= rd_idx;
            m_last  <= (rd_idx == 11'd2047);
            rd_done <= (rd_idx == 11'd2047);
            rd_idx  <= rd_idx + 1'b1;
        end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end
    end

endmodule
